// File: rtl/ready_4.sv
// Occupancy decoder for a circular buffer: turns write/read pointers plus the
// lap flag into a registered per-slot ready mask. Optional status outputs
// (Count/Full/Empty) are enabled by defining READY_4_STATUS_EN.
module ready_4 #(
  parameter int BufferWidth = 2,
  parameter int BufferSize  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [BufferWidth-1:0] W_Addr,
  input  logic [BufferWidth-1:0] R_Addr,
  input  logic                   Round,
`ifdef READY_4_STATUS_EN
  output logic [BufferWidth:0]   Count,
  output logic                   Full,
  output logic                   Empty,
`endif
  output logic [BufferSize-1:0]  Ready
);

  // Slot indices and pointers are compared one bit wider so the top slot index
  // never wraps to zero.
  localparam int CmpWidth = BufferWidth + 1;

  logic [CmpWidth-1:0]   w_w_ext;
  logic [CmpWidth-1:0]   w_r_ext;
  logic [BufferSize-1:0] w_ge_r;
  logic [BufferSize-1:0] w_lt_w;
  logic [BufferSize-1:0] w_ready_nxt;
  logic [BufferSize-1:0] r_ready;

  assign w_w_ext = {1'b0, W_Addr};
  assign w_r_ext = {1'b0, R_Addr};

  for (genvar i = 0; i < BufferSize; i++) begin : g_slot
    localparam logic [CmpWidth-1:0] SlotIdx = CmpWidth'(i);
    assign w_ge_r[i] = (SlotIdx >= w_r_ext);
    assign w_lt_w[i] = (SlotIdx <  w_w_ext);
  end

  // Same lap: occupied slots lie between the pointers. Wrapped lap: the union
  // of R_Addr..top and 0..W_Addr-1.
  assign w_ready_nxt = Round ? (w_ge_r | w_lt_w) : (w_ge_r & w_lt_w);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the same pre-edge snapshot of its inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready <= '0;
    end else begin
      r_ready <= w_ready_nxt;
    end
  end

  assign Ready = r_ready;

`ifdef READY_4_STATUS_EN
  logic [CmpWidth-1:0] w_count_nxt;
  logic [CmpWidth-1:0] r_count;
  logic                r_full;
  logic                r_empty;

  // NOTE: the accumulator gets its default before the loop, so no latch is
  // inferred for it.
  always_comb begin
    w_count_nxt = '0;
    for (int i = 0; i < BufferSize; i++) begin
      w_count_nxt = w_count_nxt + CmpWidth'(w_ready_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CmpWidth'(BufferSize));
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign Count = r_count;
  assign Full  = r_full;
  assign Empty = r_empty;
`endif

endmodule

// File: tb/tb_ready_4.sv
// Scoreboard bench for ready_4: the driver pushes the occupancy predicted by a
// pointer-walking model, and a monitor pops and compares after each rising edge.
module tb_ready_4;

  localparam int BW = 2;
  localparam int BS = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [BW-1:0] w_addr;
  logic [BW-1:0] r_addr;
  logic          round;
  logic [BS-1:0] ready;
`ifdef READY_4_STATUS_EN
  logic [BW:0]   count;
  logic          full;
  logic          empty;
`endif

  ready_4 #(.BufferWidth(BW), .BufferSize(BS)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .W_Addr (w_addr),
    .R_Addr (r_addr),
    .Round  (round),
`ifdef READY_4_STATUS_EN
    .Count  (count),
    .Full   (full),
    .Empty  (empty),
`endif
    .Ready  (ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [BS-1:0] mask;
    logic [BW:0]   cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: walk forward from the read pointer over the occupied slots.
  // Inconsistent pointer states saturate to empty (same lap) or full (wrapped).
  function automatic exp_t model(input int w, input int r, input bit rnd);
    exp_t e;
    int   occ;
    e = '0;
    if (!rnd) occ = (w >= r) ? (w - r) : 0;
    else      occ = (w <= r) ? (BS - r + w) : BS;
    for (int k = 0; k < occ; k++) e.mask[(r + k) % BS] = 1'b1;
    e.cnt = (BW + 1)'(occ);
    return e;
  endfunction

  task automatic drive(input int w, input int r, input bit rnd);
    @(negedge clk);
    w_addr = BW'(w);
    r_addr = BW'(r);
    round  = rnd;
    sb_q.push_back(model(w, r, rnd));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(ready), 32'h0);
`ifdef READY_4_STATUS_EN
    check({tag, "_count"}, 32'(count), 32'h0);
    check({tag, "_full"},  32'(full),  32'h0);
    check({tag, "_empty"}, 32'(empty), 32'h1);
`endif
  endtask

  // Monitor: one expectation is consumed per rising edge out of reset.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("ready", 32'(ready), 32'(e.mask));
`ifdef READY_4_STATUS_EN
        check("count", 32'(count), 32'(e.cnt));
        check("full",  32'(full),  32'(e.cnt == (BW + 1)'(BS)));
        check("empty", 32'(empty), 32'(e.cnt == '0));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int budget;
    rst_n  = 1'b0;
    w_addr = 2'd3;
    r_addr = 2'd0;
    round  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");

    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    drive(3, 1, 1'b0);   // 0110
    drive(2, 2, 1'b0);   // 0000, empty
    drive(2, 2, 1'b1);   // 1111, full
    drive(1, 3, 1'b1);   // 1001 wrap-around

    // Free-running sweep, including inconsistent pointer states.
    for (int c = 0; c < 64; c++) drive(c % BS, (c / 4) % BS, bit'((c / 16) % 2));

    // Random snapshots.
    for (int n = 0; n < 200; n++)
      drive(int'($urandom_range(BS - 1)), int'($urandom_range(BS - 1)), bit'($urandom_range(1)));

    // Mid-operation reset between edges while Ready=0110.
    drive(3, 1, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk);
    #1;
    check_reset_outputs("held_reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_ready", 32'(ready), 32'h0);
    @(posedge clk);
    #1;
    check("resume_ready", 32'(ready), 32'h6);

    budget = 10;
    while (sb_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    check("drain", 32'(sb_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
